// File: rtl/aes_uart_regs_fifo.sv
// AES-UART AXI4-Lite register file with TX/RX byte FIFOs, key banks,
// AES block staging registers, sticky/live status and a maskable interrupt.
module aes_uart_regs_fifo #(
  parameter int ADDR_W    = 32,
  parameter int TX_DEPTH  = 8,
  parameter int RX_DEPTH  = 8,
  parameter int KEY_WORDS = 8,
  parameter int BLK_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [31:0]             s_wdata,
  input  logic [3:0]              s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_W-1:0]       s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [31:0]             o_cr1,
  output logic [31:0]             o_cr2,
  output logic [31:0]             o_brr,
  output logic [32*KEY_WORDS-1:0] o_ekr,
  output logic [32*KEY_WORDS-1:0] o_dkr,
  output logic                    o_ekey_update,
  output logic                    o_dkey_update,
  output logic [7:0]              m_tdr_tdata,
  output logic                    m_tdr_tvalid,
  input  logic                    m_tdr_tready,
  input  logic [7:0]              s_rdr_tdata,
  input  logic                    s_rdr_tvalid,
  output logic                    s_rdr_tready,
  output logic [32*BLK_WORDS-1:0] m_epr_tdata,
  output logic                    m_epr_tvalid,
  input  logic                    m_epr_tready,
  input  logic [32*BLK_WORDS-1:0] s_dpr_tdata,
  input  logic                    s_dpr_tvalid,
  output logic                    s_dpr_tready,
  input  logic [4:0]              i_evt,
  input  logic                    i_busy,
  output logic                    irq
);

  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [7:0]  A_CR1 = 8'h00, A_CR2 = 8'h04, A_BRR = 8'h08, A_ISR = 8'h0C;
  localparam logic [7:0]  A_ICR = 8'h10, A_RDR = 8'h14, A_TDR = 8'h18, A_IER = 8'h1C;
  localparam logic [7:0]  A_FSR = 8'h20;
  localparam logic [7:0]  A_EKR_LAST = 8'(32'h40 + 4 * (KEY_WORDS - 1));
  localparam logic [7:0]  A_DKR_LAST = 8'(32'h60 + 4 * (KEY_WORDS - 1));
  localparam logic [7:0]  A_EPR_LAST = 8'(32'h80 + 4 * (BLK_WORDS - 1));
  localparam logic [7:0]  A_DPR_LAST = 8'(32'h90 + 4 * (BLK_WORDS - 1));
  // txe, txfe and ere are already true for empty FIFOs / empty EPR
  localparam logic [12:0] ISR_RST = 13'h08C0;

  function automatic logic [31:0] f_bmask(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
    logic [31:0] m;
    m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_v & ~m) | (new_v & m);
  endfunction

  logic                          r_aw_full, r_w_full, r_bvalid, r_rvalid, r_irq;
  logic [7:0]                    r_awaddr;
  logic [31:0]                   r_wdata, r_rdata, r_cr1, r_cr2, r_brr, r_ier;
  logic [3:0]                    r_wstrb;
  logic [1:0]                    r_bresp, r_rresp;
  logic [12:0]                   r_isr;
  logic [KEY_WORDS-1:0][31:0]    r_ekr, r_dkr;
  logic [BLK_WORDS-1:0][31:0]    r_epr, r_dpr;
  logic                          r_epr_valid, r_dpr_full, r_ekey_upd, r_dkey_upd;
  logic [7:0]                    r_txm [TX_DEPTH];
  logic [7:0]                    r_rxm [RX_DEPTH];
  logic [TXA-1:0]                r_txw, r_txr;
  logic [RXA-1:0]                r_rxw, r_rxr;
  logic [TXA:0]                  r_txc;
  logic [RXA:0]                  r_rxc;

  logic        w_commit, w_ekr_hit, w_dkr_hit, w_epr_hit, w_wok, w_tdr_sel;
  logic        w_tx_push, w_tx_pop, w_tx_ovf, w_tx_full, w_tx_empty, w_epr_wr;
  logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_ar_hs, w_dpr_rel;
  logic [1:0]  w_bresp, w_rresp;
  logic [31:0] w_icr_clr, w_rd, w_fsr;
  logic [7:0]  w_roff;
  logic        w_unused_addr;

  assign w_unused_addr = ^{s_awaddr[ADDR_W-1:8], s_araddr[ADDR_W-1:8]};
  assign w_commit   = r_aw_full & r_w_full & ~r_bvalid;
  assign w_tx_full  = (r_txc == (TXA+1)'(TX_DEPTH));
  assign w_tx_empty = (r_txc == '0);
  assign w_rx_full  = (r_rxc == (RXA+1)'(RX_DEPTH));
  assign w_rx_empty = (r_rxc == '0);
  assign w_tx_pop   = ~w_tx_empty & m_tdr_tready;
  assign w_rx_push  = s_rdr_tvalid & ~w_rx_full;
  assign w_roff     = s_araddr[7:0];
  assign w_ar_hs    = s_arvalid & ~r_rvalid;
  assign w_rx_pop   = w_ar_hs & (w_roff == A_RDR) & ~w_rx_empty;
  assign w_dpr_rel  = w_ar_hs & (w_roff == A_DPR_LAST);
  assign w_fsr      = {16'b0, 8'(r_rxc), 8'(r_txc)};

  assign s_awready     = ~r_aw_full;
  assign s_wready      = ~r_w_full;
  assign s_bvalid      = r_bvalid;
  assign s_bresp       = r_bresp;
  assign s_arready     = ~r_rvalid;
  assign s_rvalid      = r_rvalid;
  assign s_rdata       = r_rdata;
  assign s_rresp       = r_rresp;
  assign o_cr1         = r_cr1;
  assign o_cr2         = r_cr2;
  assign o_brr         = r_brr;
  assign o_ekr         = r_ekr;
  assign o_dkr         = r_dkr;
  assign o_ekey_update = r_ekey_upd;
  assign o_dkey_update = r_dkey_upd;
  assign m_tdr_tvalid  = ~w_tx_empty;
  assign m_tdr_tdata   = w_tx_empty ? '0 : r_txm[r_txr];
  assign s_rdr_tready  = ~w_rx_full;
  assign m_epr_tvalid  = r_epr_valid;
  assign m_epr_tdata   = r_epr;
  assign s_dpr_tready  = ~r_dpr_full;
  assign irq           = r_irq;

  // Write decode of the committed AW/W pair: response code and side-effect strobes
  always_comb begin
    w_ekr_hit = 1'b0;
    w_dkr_hit = 1'b0;
    w_epr_hit = 1'b0;
    for (int unsigned i = 0; i < KEY_WORDS; i++) begin
      if (r_awaddr == 8'(32'h40 + 4 * i)) w_ekr_hit = 1'b1;
      if (r_awaddr == 8'(32'h60 + 4 * i)) w_dkr_hit = 1'b1;
    end
    for (int unsigned i = 0; i < BLK_WORDS; i++)
      if (r_awaddr == 8'(32'h80 + 4 * i)) w_epr_hit = 1'b1;
    w_tdr_sel = (r_awaddr == A_TDR) & r_wstrb[0];
    w_tx_ovf  = w_commit & w_tdr_sel & w_tx_full;
    w_tx_push = w_commit & w_tdr_sel & ~w_tx_full;
    w_epr_wr  = w_commit & w_epr_hit & ~r_epr_valid;
    w_icr_clr = (w_commit && r_awaddr == A_ICR) ? f_bmask('0, r_wdata, r_wstrb) : '0;
    w_wok = (r_awaddr == A_CR1) | (r_awaddr == A_CR2) | (r_awaddr == A_BRR) |
            (r_awaddr == A_IER) | (r_awaddr == A_ICR) | w_ekr_hit | w_dkr_hit |
            ((r_awaddr == A_TDR) & ~(r_wstrb[0] & w_tx_full)) |
            (w_epr_hit & ~r_epr_valid);
    w_bresp = w_wok ? OKAY : SLVERR;
  end

  // Independent AW/W holders and the write response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      if (s_awvalid && !r_aw_full) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= s_awaddr[7:0];
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end
      if (s_wvalid && !r_w_full) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_wdata;
        r_wstrb  <= s_wstrb;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_bresp;
      end else if (s_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // RW registers, key banks, EPR staging and key-commit pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cr1       <= '0;
      r_cr2       <= '0;
      r_brr       <= '0;
      r_ier       <= '0;
      r_ekr       <= '0;
      r_dkr       <= '0;
      r_epr       <= '0;
      r_epr_valid <= 1'b0;
      r_ekey_upd  <= 1'b0;
      r_dkey_upd  <= 1'b0;
    end else begin
      r_ekey_upd <= w_commit && r_awaddr == A_EKR_LAST;
      r_dkey_upd <= w_commit && r_awaddr == A_DKR_LAST;
      if (w_commit) begin
        if (r_awaddr == A_CR1) r_cr1 <= f_bmask(r_cr1, r_wdata, r_wstrb);
        if (r_awaddr == A_CR2) r_cr2 <= f_bmask(r_cr2, r_wdata, r_wstrb);
        if (r_awaddr == A_BRR) r_brr <= f_bmask(r_brr, r_wdata, r_wstrb);
        if (r_awaddr == A_IER) r_ier <= f_bmask(r_ier, r_wdata, r_wstrb);
        for (int unsigned i = 0; i < KEY_WORDS; i++) begin
          if (r_awaddr == 8'(32'h40 + 4 * i)) r_ekr[i] <= f_bmask(r_ekr[i], r_wdata, r_wstrb);
          if (r_awaddr == 8'(32'h60 + 4 * i)) r_dkr[i] <= f_bmask(r_dkr[i], r_wdata, r_wstrb);
        end
      end
      for (int unsigned i = 0; i < BLK_WORDS; i++)
        if (w_epr_wr && r_awaddr == 8'(32'h80 + 4 * i)) r_epr[i] <= f_bmask(r_epr[i], r_wdata, r_wstrb);
      if (w_epr_wr && r_awaddr == A_EPR_LAST) r_epr_valid <= 1'b1;
      else if (m_epr_tready)                  r_epr_valid <= 1'b0;
    end
  end

  // DPR capture: one beat fills all words, the last-word read releases it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dpr      <= '0;
      r_dpr_full <= 1'b0;
    end else if (s_dpr_tvalid && !r_dpr_full) begin
      r_dpr      <= s_dpr_tdata;
      r_dpr_full <= 1'b1;
    end else if (w_dpr_rel) begin
      r_dpr_full <= 1'b0;
    end
  end

  // Read data mux; ICR/TDR and unmapped offsets fall to SLVERR
  always_comb begin
    w_rd    = '0;
    w_rresp = OKAY;
    case (w_roff)
      A_CR1:   w_rd = r_cr1;
      A_CR2:   w_rd = r_cr2;
      A_BRR:   w_rd = r_brr;
      A_ISR:   w_rd = {19'b0, r_isr};
      A_RDR:   w_rd = w_rx_empty ? '0 : {24'b0, r_rxm[r_rxr]};
      A_IER:   w_rd = r_ier;
      A_FSR:   w_rd = w_fsr;
      default: begin
        w_rresp = SLVERR;
        for (int unsigned i = 0; i < KEY_WORDS; i++) begin
          if (w_roff == 8'(32'h40 + 4 * i)) begin w_rd = r_ekr[i]; w_rresp = OKAY; end
          if (w_roff == 8'(32'h60 + 4 * i)) begin w_rd = r_dkr[i]; w_rresp = OKAY; end
        end
        for (int unsigned i = 0; i < BLK_WORDS; i++) begin
          if (w_roff == 8'(32'h80 + 4 * i)) begin w_rd = r_epr[i]; w_rresp = OKAY; end
          if (w_roff == 8'(32'h90 + 4 * i)) begin w_rd = r_dpr[i]; w_rresp = OKAY; end
        end
      end
    endcase
  end

  // Read response register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd;
      r_rresp  <= w_rresp;
    end else if (s_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // Status register (sticky bits: set beats clear) and registered interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_isr <= ISR_RST;
      r_irq <= 1'b0;
    end else begin
      r_isr[4:0] <= (r_isr[4:0] & ~w_icr_clr[4:0]) | i_evt;
      r_isr[5]   <= ~w_rx_empty;
      r_isr[6]   <= ~w_tx_full;
      r_isr[7]   <= w_tx_empty;
      r_isr[8]   <= w_rx_full;
      r_isr[9]   <= (r_isr[9] & ~w_icr_clr[9]) | w_tx_ovf;
      r_isr[10]  <= r_dpr_full;
      r_isr[11]  <= ~r_epr_valid;
      r_isr[12]  <= i_busy;
      r_irq      <= |(r_isr & r_ier[12:0]);
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (!rst && w_tx_push) r_txm[r_txw] <= r_wdata[7:0];
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (!rst && w_rx_push) r_rxm[r_rxw] <= s_rdr_tdata;
  end

  // FIFO pointers and levels; push+pop together hold the level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txw <= '0;
      r_txr <= '0;
      r_txc <= '0;
      r_rxw <= '0;
      r_rxr <= '0;
      r_rxc <= '0;
    end else begin
      if (w_tx_push) r_txw <= r_txw + 1'b1;
      if (w_tx_pop)  r_txr <= r_txr + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_txc <= r_txc + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_txc <= r_txc - 1'b1;
      if (w_rx_push) r_rxw <= r_rxw + 1'b1;
      if (w_rx_pop)  r_rxr <= r_rxr + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rxc <= r_rxc + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rxc <= r_rxc - 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_uart_regs_fifo.sv
// Directed self-checking bench for aes_uart_regs_fifo.
module tb_aes_uart_regs_fifo;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic         s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic [3:0]   s_wstrb = '0;
  logic         s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]   s_bresp, s_rresp;
  logic [31:0]  s_rdata, o_cr1, o_cr2, o_brr;
  logic [255:0] o_ekr, o_dkr;
  logic         o_ekey_update, o_dkey_update;
  logic [7:0]   m_tdr_tdata, s_rdr_tdata = '0;
  logic         m_tdr_tvalid, m_tdr_tready = 0, s_rdr_tvalid = 0, s_rdr_tready;
  logic [127:0] m_epr_tdata, s_dpr_tdata = '0;
  logic         m_epr_tvalid, m_epr_tready = 0, s_dpr_tvalid = 0, s_dpr_tready;
  logic [4:0]   i_evt = '0;
  logic         i_busy = 0, irq;

  int           n_chk = 0, n_pass = 0, n_ekupd = 0;
  logic         ek_at_b = 0;
  logic [1:0]   resp, rr;
  logic [31:0]  rd;
  logic [255:0] exp_key;
  logic [127:0] exp_blk;

  always #5 clk = ~clk;

  aes_uart_regs_fifo #(
    .ADDR_W(32), .TX_DEPTH(8), .RX_DEPTH(8), .KEY_WORDS(8), .BLK_WORDS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .o_cr1(o_cr1), .o_cr2(o_cr2), .o_brr(o_brr), .o_ekr(o_ekr), .o_dkr(o_dkr),
    .o_ekey_update(o_ekey_update), .o_dkey_update(o_dkey_update),
    .m_tdr_tdata(m_tdr_tdata), .m_tdr_tvalid(m_tdr_tvalid), .m_tdr_tready(m_tdr_tready),
    .s_rdr_tdata(s_rdr_tdata), .s_rdr_tvalid(s_rdr_tvalid), .s_rdr_tready(s_rdr_tready),
    .m_epr_tdata(m_epr_tdata), .m_epr_tvalid(m_epr_tvalid), .m_epr_tready(m_epr_tready),
    .s_dpr_tdata(s_dpr_tdata), .s_dpr_tvalid(s_dpr_tvalid), .s_dpr_tready(s_dpr_tready),
    .i_evt(i_evt), .i_busy(i_busy), .irq(irq)
  );

  always @(negedge clk) if (o_ekey_update) n_ekupd++;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] r);
    bit aw_hs, w_hs;
    int cyc;
    cyc = 0;
    s_awaddr = 32'(a); s_wdata = d; s_wstrb = st; s_awvalid = 1; s_wvalid = 1;
    while ((s_awvalid || s_wvalid) && cyc < 50) begin
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      @(posedge clk); #1; cyc++;
      if (aw_hs) s_awvalid = 0;
      if (w_hs)  s_wvalid = 0;
    end
    s_bready = 1;
    while (!s_bvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    r = s_bresp;
    ek_at_b = o_ekey_update;
    @(posedge clk); #1;
    s_bready = 0; s_awvalid = 0; s_wvalid = 0;
    if (cyc >= 50) check("wr_timeout", 256'(cyc), 256'(0));
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    bit ar_hs;
    int cyc;
    cyc = 0;
    s_araddr = 32'(a); s_arvalid = 1;
    while (s_arvalid && cyc < 50) begin
      ar_hs = s_arvalid && s_arready;
      @(posedge clk); #1; cyc++;
      if (ar_hs) s_arvalid = 0;
    end
    s_rready = 1;
    while (!s_rvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    d = s_rdata;
    r = s_rresp;
    @(posedge clk); #1;
    s_rready = 0; s_arvalid = 0;
    if (cyc >= 50) check("rd_timeout", 256'(cyc), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    rst = 0;
    // reset state
    check("rst_awready", s_awready, 1);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_irq", irq, 0);
    check("rst_rdr_tready", s_rdr_tready, 1);
    check("rst_dpr_tready", s_dpr_tready, 1);
    check("rst_tdr_tvalid", m_tdr_tvalid, 0);
    check("rst_epr_tvalid", m_epr_tvalid, 0);
    check("rst_cr1", o_cr1, 0);
    axi_read(8'h0C, rd, rr);
    check("rst_isr", rd, 32'h8C0);

    // W three cycles ahead of AW, strobed CR1 write
    s_wdata = 32'h12345678; s_wstrb = 4'b0101; s_wvalid = 1;
    tick(1); s_wvalid = 0;
    tick(2);
    check("w_hold_full", s_wready, 0);
    check("no_early_b", s_bvalid, 0);
    s_awaddr = 32'h0; s_awvalid = 1;
    tick(1); s_awvalid = 0;
    tick(1);
    check("b_valid", s_bvalid, 1);
    check("b_resp_cr1", s_bresp, 0);
    check("cr1_strobed", o_cr1, 32'h00340078);
    s_bready = 1; tick(1); s_bready = 0;
    tick(3);
    check("single_b", s_bvalid, 0);

    // TX FIFO fill, overflow, drain, W1C
    for (int i = 1; i <= 8; i++) begin
      axi_write(8'h18, 32'(i), 4'h1, resp);
      check("tdr_okay", resp, 0);
    end
    axi_write(8'h18, 32'h9, 4'h1, resp);
    check("tdr_ovf_slverr", resp, 2'b10);
    axi_read(8'h20, rd, rr);
    check("fsr_tx8", rd, 32'h8);
    axi_read(8'h0C, rd, rr);
    check("isr_txovf", rd, 32'hA00);
    m_tdr_tready = 1;
    for (int i = 0; i < 8; i++) begin
      check("tx_byte", m_tdr_tdata, 256'(i + 1));
      tick(1);
    end
    check("tx_drained", m_tdr_tvalid, 0);
    axi_write(8'h10, 32'h200, 4'hF, resp);
    axi_read(8'h0C, rd, rr);
    check("isr_txovf_clr", rd, 32'h8C0);

    // RX bytes, reads including empty
    s_rdr_tdata = 8'hA5; s_rdr_tvalid = 1; tick(1);
    s_rdr_tdata = 8'h5A; tick(1);
    s_rdr_tvalid = 0; tick(1);
    axi_read(8'h0C, rd, rr);
    check("isr_rxne", rd, 32'h8E0);
    axi_read(8'h14, rd, rr);
    check("rdr_a5", rd, 32'hA5);
    axi_read(8'h14, rd, rr);
    check("rdr_5a", rd, 32'h5A);
    axi_read(8'h14, rd, rr);
    check("rdr_empty_data", rd, 0);
    check("rdr_empty_resp", rr, 0);
    axi_read(8'h0C, rd, rr);
    check("isr_rxne_clr", rd, 32'h8C0);

    // RX full, pop with producer still presenting keeps level at 8
    for (int i = 0; i < 8; i++) begin
      s_rdr_tdata = 8'(8'h10 + i); s_rdr_tvalid = 1; tick(1);
    end
    check("rx_full_tready", s_rdr_tready, 0);
    s_rdr_tdata = 8'h99;
    axi_read(8'h20, rd, rr);
    check("fsr_rx8", rd, 32'h800);
    axi_read(8'h14, rd, rr);
    check("rdr_first", rd, 32'h10);
    s_rdr_tvalid = 0;
    axi_read(8'h20, rd, rr);
    check("fsr_rx8_kept", rd, 32'h800);
    axi_read(8'h0C, rd, rr);
    check("isr_rxff", rd, 32'h9E0);
    for (int i = 0; i < 8; i++) begin
      axi_read(8'h14, rd, rr);
      check("rdr_drain", rd, (i < 7) ? 256'(32'h11 + i) : 256'(32'h99));
    end

    // Encryption key bank and commit pulse
    exp_key = '0;
    for (int i = 0; i < 8; i++) begin
      axi_write(8'(8'h40 + 4 * i), 32'hA0B0C000 + 32'(i), 4'hF, resp);
      exp_key[i*32 +: 32] = 32'hA0B0C000 + 32'(i);
      if (i == 6) check("ekupd_not_early", 256'(n_ekupd), 0);
    end
    check("ekupd_at_b", ek_at_b, 1);
    tick(3);
    check("ekupd_once", 256'(n_ekupd), 1);
    check("ekr_value", o_ekr, exp_key);

    // EPR block and busy-write rejection
    exp_blk = '0;
    for (int i = 0; i < 4; i++) begin
      axi_write(8'(8'h80 + 4 * i), 32'hE0000000 + 32'(i), 4'hF, resp);
      exp_blk[i*32 +: 32] = 32'hE0000000 + 32'(i);
      if (i == 2) check("epr_not_yet", m_epr_tvalid, 0);
    end
    check("epr_tvalid", m_epr_tvalid, 1);
    check("epr_tdata", m_epr_tdata, exp_blk);
    axi_write(8'h80, 32'hDEADBEEF, 4'hF, resp);
    check("epr_busy_slverr", resp, 2'b10);
    check("epr_unchanged", m_epr_tdata, exp_blk);
    m_epr_tready = 1; tick(1); m_epr_tready = 0;
    check("epr_consumed", m_epr_tvalid, 0);

    // DPR capture and release
    s_dpr_tdata = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
    s_dpr_tvalid = 1; tick(1); s_dpr_tvalid = 0;
    check("dpr_tready_low", s_dpr_tready, 0);
    axi_read(8'h90, rd, rr);
    check("dpr0", rd, 32'hD0D0D0D0);
    axi_read(8'h9C, rd, rr);
    check("dpr3", rd, 32'hD3D3D3D3);
    check("dpr_released", s_dpr_tready, 1);

    // Interrupt, clear vs. set race, error offsets
    axi_write(8'h1C, 32'h10, 4'hF, resp);
    i_evt = 5'h10; tick(1); i_evt = 0;
    tick(1);
    check("irq_set", irq, 1);
    s_awaddr = 32'h10; s_wdata = 32'h10; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    tick(1);
    s_awvalid = 0; s_wvalid = 0; i_evt = 5'h10;
    tick(1);
    i_evt = 0;
    check("icr_race_b", s_bvalid, 1);
    s_bready = 1; tick(1); s_bready = 0;
    axi_read(8'h0C, rd, rr);
    check("isr_set_wins", rd, 32'h8D0);
    check("irq_held", irq, 1);
    axi_write(8'h10, 32'h10, 4'hF, resp);
    tick(2);
    check("irq_cleared", irq, 0);
    i_busy = 1; tick(2);
    axi_read(8'h0C, rd, rr);
    check("isr_busy", rd, 32'h18C0);
    i_busy = 0;
    axi_read(8'hFC, rd, rr);
    check("unmapped_rdata", rd, 0);
    check("unmapped_rresp", rr, 2'b10);
    axi_write(8'h0C, 32'hFFFF, 4'hF, resp);
    check("ro_write_slverr", resp, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_uart_regs_fifo.md
Name: aes_uart_regs_fifo

Overview:
- Second-generation AXI4-Lite register file for the AES-UART core.
- CPU-facing configuration, status and data-path registers on one side; UART byte streams and AES block streams on the other.
- Adds parametrised TX/RX FIFOs behind TDR/RDR, parametrised key/block widths and byte-strobe writes.
- Adds independent AW/W acceptance, SLVERR reporting and a maskable interrupt output.

Parameters:
ADDR_W, 32, AXI-Lite address width; only addr[7:0] is decoded.
TX_DEPTH, 8, TX FIFO entries (power of 2, 2..128).
RX_DEPTH, 8, RX FIFO entries (power of 2, 2..128).
KEY_WORDS, 8, 32-bit words per key register bank (4, 6 or 8).
BLK_WORDS, 4, 32-bit words per AES block (fixed 4 for AES; kept as a parameter).

Ports:
clk in 1 clock
rst in 1 reset, synchronous, active-high
s_awaddr/s_awvalid/s_awready in/in/out ADDR_W/1/1 AXI-Lite write address
s_wdata/s_wstrb/s_wvalid/s_wready in/in/in/out 32/4/1/1 AXI-Lite write data
s_bresp/s_bvalid/s_bready out/out/in 2/1/1 write response
s_araddr/s_arvalid/s_arready in/in/out ADDR_W/1/1 read address
s_rdata/s_rresp/s_rvalid/s_rready out/out/out/in 32/2/1/1 read data
o_cr1/o_cr2/o_brr out 32 each, control registers
o_ekr/o_dkr out 32*KEY_WORDS each, encryption/decryption keys
o_ekey_update/o_dkey_update out 1 each, key-commit pulses
m_tdr_tdata/tvalid/tready out/out/in 8/1/1 TX byte stream
s_rdr_tdata/tvalid/tready in/in/out 8/1/1 RX byte stream
m_epr_tdata/tvalid/tready out/out/in 32*BLK_WORDS/1/1 plaintext block to encryptor
s_dpr_tdata/tvalid/tready in/in/out 32*BLK_WORDS/1/1 decrypted block
i_evt in 5 one-cycle event pulses: [0]pe [1]fe [2]ore [3]idle [4]tc
i_busy in 1 core busy
irq out 1 interrupt

Behaviour:
Map (byte offsets; RW unless noted):
- CR1 0x00, CR2 0x04, BRR 0x08, ISR 0x0C (RO), ICR 0x10 (WO, W1C).
- RDR 0x14 (RO, pop), TDR 0x18 (WO, push), IER 0x1C, FSR 0x20 (RO: [7:0] TX level, [15:8] RX level).
- EKR 0x40+4i, DKR 0x60+4i (i < KEY_WORDS); EPR 0x80+4i, DPR 0x90+4i (i < BLK_WORDS; EPR RW, DPR RO).

ISR bits:
- Sticky: [0]pe [1]fe [2]ore [3]idle [4]tc, set by i_evt; [9]txovf.
- Live: [5]rxne = RX level != 0; [6]txe = TX FIFO not full; [7]txfe = TX empty; [8]rxff = RX full; [10]drne = DPR holds data; [11]ere = EPR empty; [12]busy = i_busy.
- ISR is registered, so live bits lag by one cycle.
- ICR bit n clears sticky ISR bit n. Event and clear in the same cycle: set wins.
- irq = |(ISR & IER), registered.

Write channel:
- AW and W are captured into independent holding registers. awready = AW holder empty; wready = W holder empty. Holders load in any order.
- Commit occurs in the cycle both holders are full and bvalid=0. Holders are freed at commit; bvalid rises the next cycle and holds until bready.
- wstrb byte-masks all RW registers.
- TDR push requires wstrb[0].
- Write to TDR while the TX FIFO is full: byte dropped, txovf set, SLVERR.
- Write to EPR while m_epr_tvalid=1: ignored, SLVERR.
- Write to a RO or unmapped offset: ignored, SLVERR. Otherwise OKAY.
- Commit to the highest EPR word asserts m_epr_tvalid next cycle; it stays high until tready.
- Commit to EKR[KEY_WORDS-1] / DKR[KEY_WORDS-1] pulses o_ekey_update / o_dkey_update for 1 cycle, the cycle after commit.

Read channel:
- arready = !rvalid.
- On AR handshake, rdata/rresp are registered and rvalid rises the next cycle, held until rready.
- RDR read pops one entry; data is zero-extended.
- RDR read while empty returns 0 with OKAY and no pop.
- Reading the highest DPR word releases DPR: s_dpr_tready rises again next cycle.
- Unmapped or WO offset: rdata 0, SLVERR.

FIFOs and streams:
- m_tdr_tvalid = TX not empty.
- s_rdr_tready = RX not full.
- Push and pop in the same cycle leave the level unchanged, including at full and empty.
- Pointers wrap modulo depth.
- s_dpr_tready = 1 while DPR is empty; a beat loads all words and drops tready.

Reset:
- All outputs, ISR, IER and registers go to 0, except s_rdr_tready=1, s_dpr_tready=1 and ISR txe/txfe/ere=1 from the first cycle after reset.
- FIFOs are emptied.
- A transaction in flight during reset is discarded; no response is issued.

Test Plan:
- W presented 3 cycles before AW, CR1 0x00 write 0x12345678 with wstrb=0b0101 -> single commit, o_cr1=0x00340078, bresp OKAY.
- 9 TDR writes with TX_DEPTH=8, m_tdr_tready=0 -> FSR[7:0]=8, 9th write gets SLVERR, ISR[9]=1. Then tready=1 -> bytes 1..8 emitted in order. ICR write 0x200 clears txovf.
- RX: stream 0xA5, 0x5A; read RDR x3 -> 0xA5, 0x5A, 0; ISR[5] goes 1 then 0. Push plus pop in the same cycle at full keeps level 8.
- Write EKR0..7 -> o_ekey_update pulses exactly once, 1 cycle after the EKR7 commit; o_ekr matches the written words.
- Write EPR0..3 -> m_epr_tvalid=1 with {w3,w2,w1,w0}. Rewrite EPR0 before tready -> SLVERR, data unchanged.
- IER=0x10, i_evt[4] pulse -> irq=1 within 2 cycles. ICR 0x10 in the same cycle as a new tc pulse -> bit stays set. Read 0xFC -> rdata 0, SLVERR.
